// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one 32-bit shifter (SLL, optional SRA) between two
// requesters, with a single registered response slot. SRA unit enabled by SHIFT_ARB_SRA_EN.
module shift_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_data,
  input  logic [SHW-1:0]   req0_shamt,
  input  logic             req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_data,
  input  logic [SHW-1:0]   req1_shamt,
  input  logic             req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy
);

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_e;

  logic             rsp_valid_q, rsp_valid_d;
  port_e            rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  port_e            last_grant_q, last_grant_d;

  logic             grant_valid;
  port_e            grant_id;
  logic             slot_free;
  logic             accept;
  logic [WIDTH-1:0] sel_data;
  logic [SHW-1:0]   sel_shamt;
  logic [WIDTH-1:0] sll_res;
  logic [WIDTH-1:0] shift_res;

  always_comb begin
    grant_valid = req0_valid | req1_valid;
    grant_id    = PORT0;
    if (req0_valid && req1_valid) begin
      grant_id = (last_grant_q == PORT0) ? PORT1 : PORT0;
    end else if (req1_valid) begin
      grant_id = PORT1;
    end
  end

  // Ready is gated by reset so nothing is accepted while the block is held in reset.
  always_comb begin
    slot_free  = !rsp_valid_q || rsp_ready;
    req0_ready = reset && grant_valid && (grant_id == PORT0) && slot_free;
    req1_ready = reset && grant_valid && (grant_id == PORT1) && slot_free;
    accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
  end

  always_comb begin
    sel_data  = (grant_id == PORT1) ? req1_data  : req0_data;
    sel_shamt = (grant_id == PORT1) ? req1_shamt : req0_shamt;
    sll_res   = sel_data << sel_shamt;
  end

`ifdef SHIFT_ARB_SRA_EN
  logic             sel_op;
  logic [WIDTH-1:0] sra_res;

  always_comb begin
    sel_op    = (grant_id == PORT1) ? req1_op : req0_op;
    sra_res   = $signed(sel_data) >>> sel_shamt;
    shift_res = sel_op ? sra_res : sll_res;
  end
`else
  logic unused_op;

  always_comb begin
    unused_op = req0_op ^ req1_op;
    shift_res = sll_res;
  end
`endif

  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    last_grant_d = last_grant_q;
    if (accept) begin
      rsp_valid_d  = 1'b1;
      rsp_id_d     = grant_id;
      rsp_data_d   = shift_res;
      last_grant_d = grant_id;
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= PORT0;
      rsp_data_q   <= '0;
      last_grant_q <= PORT1;
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    rsp_valid = rsp_valid_q;
    rsp_id    = rsp_id_q;
    rsp_data  = rsp_data_q;
    busy      = rsp_valid_q | req0_valid | req1_valid;
  end

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed self-checking bench for shift_arbiter; expectations for SRA follow SHIFT_ARB_SRA_EN.
module tb_shift_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req0_op;
  logic [31:0] req0_data;
  logic [4:0]  req0_shamt;
  logic        req1_valid, req1_ready, req1_op;
  logic [31:0] req1_data;
  logic [4:0]  req1_shamt;
  logic        rsp_valid, rsp_ready, rsp_id, busy;
  logic [31:0] rsp_data;

  int n_checks = 0;
  int n_fail   = 0;

  shift_arbiter #(.WIDTH(32), .SHW(5)) dut (
    .clock      (clock),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_data  (req0_data),
    .req0_shamt (req0_shamt),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_data  (req1_data),
    .req1_shamt (req1_shamt),
    .req1_op    (req1_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  // Present one request at the current negedge, let one edge pass, then withdraw it.
  task automatic drive(input bit p, input logic [31:0] d, input logic [4:0] s, input bit op);
    if (p) begin
      req1_valid = 1'b1; req1_data = d; req1_shamt = s; req1_op = op;
    end else begin
      req0_valid = 1'b1; req0_data = d; req0_shamt = s; req0_op = op;
    end
    @(posedge clock);
    @(negedge clock);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clock);
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %0b want 0", rsp_valid); end
    n_checks++; if (rsp_id !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_id got %0b want 0", rsp_id); end
    n_checks++; if (rsp_data !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_data got %h want 00000000", rsp_data); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy_idle got %0b want 0", busy); end
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    n_checks++; if (req0_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req0_ready got %0b want 0", req0_ready); end
    n_checks++; if (req1_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req1_ready got %0b want 0", req1_ready); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy_req got %0b want 1", busy); end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_sll;
    req0_valid = 1'b1; req0_data = 32'h1; req0_shamt = 5'd4; req0_op = 1'b0;
    #1;
    n_checks++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL sll_req0_ready got %0b want 1", req0_ready); end
    drive(1'b0, 32'h0000_0001, 5'd4, 1'b0);
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL sll_rsp_valid got %0b want 1", rsp_valid); end
    n_checks++; if (rsp_id !== 1'b0) begin n_fail++; $display("FAIL sll_rsp_id got %0b want 0", rsp_id); end
    n_checks++; if (rsp_data !== 32'h0000_0010) begin n_fail++; $display("FAIL sll_rsp_data got %h want 00000010", rsp_data); end
    drive(1'b0, 32'hDEAD_BEEF, 5'd0, 1'b0);
    n_checks++; if (rsp_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL sll_shamt0 got %h want deadbeef", rsp_data); end
    @(negedge clock);
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL drain_rsp_valid got %0b want 0", rsp_valid); end
    n_checks++; if (rsp_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL drain_hold_data got %h want deadbeef", rsp_data); end
  endtask

  task automatic test_sra;
    logic [31:0] exp;
`ifdef SHIFT_ARB_SRA_EN
    exp = 32'hF800_0000;
`else
    exp = 32'h0000_0000;
`endif
    drive(1'b1, 32'h8000_0000, 5'd4, 1'b1);
    n_checks++; if (rsp_id !== 1'b1) begin n_fail++; $display("FAIL sra_rsp_id got %0b want 1", rsp_id); end
    n_checks++; if (rsp_data !== exp) begin n_fail++; $display("FAIL sra_rsp_data got %h want %h", rsp_data, exp); end
  endtask

  task automatic test_contention;
    logic [31:0] exp;
    bit          g;
    req0_valid = 1'b1; req0_data = 32'h1; req0_shamt = 5'd1; req0_op = 1'b0;
    req1_valid = 1'b1; req1_data = 32'h1; req1_shamt = 5'd2; req1_op = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      g   = (i % 2) == 1;
      exp = g ? 32'h4 : 32'h2;
      n_checks++; if (req0_ready !== !g) begin n_fail++; $display("FAIL cont_req0_ready[%0d] got %0b want %0b", i, req0_ready, !g); end
      n_checks++; if (req1_ready !== g) begin n_fail++; $display("FAIL cont_req1_ready[%0d] got %0b want %0b", i, req1_ready, g); end
      @(posedge clock);
      @(negedge clock);
      n_checks++; if (rsp_id !== g) begin n_fail++; $display("FAIL cont_rsp_id[%0d] got %0b want %0b", i, rsp_id, g); end
      n_checks++; if (rsp_data !== exp) begin n_fail++; $display("FAIL cont_rsp_data[%0d] got %h want %h", i, rsp_data, exp); end
      #1;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_back_pressure;
    req0_valid = 1'b1; req0_data = 32'h3; req0_shamt = 5'd2; req0_op = 1'b0;
    @(posedge clock);
    @(negedge clock);
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_data = 32'h5; req1_shamt = 5'd1; req1_op = 1'b0;
    rsp_ready  = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_rsp_valid[%0d] got %0b want 1", i, rsp_valid); end
      n_checks++; if (rsp_data !== 32'hC) begin n_fail++; $display("FAIL bp_rsp_data[%0d] got %h want 0000000c", i, rsp_data); end
      n_checks++; if (rsp_id !== 1'b0) begin n_fail++; $display("FAIL bp_rsp_id[%0d] got %0b want 0", i, rsp_id); end
      n_checks++; if ((req0_ready | req1_ready) !== 1'b0) begin n_fail++; $display("FAIL bp_readys[%0d] got %0b%0b want 00", i, req0_ready, req1_ready); end
      @(posedge clock);
      @(negedge clock);
      #1;
    end
    rsp_ready = 1'b1;
    #1;
    n_checks++; if (req1_ready !== 1'b1) begin n_fail++; $display("FAIL bp_refill_ready got %0b want 1", req1_ready); end
    @(posedge clock);
    @(negedge clock);
    req1_valid = 1'b0;
    n_checks++; if (rsp_id !== 1'b1) begin n_fail++; $display("FAIL bp_refill_id got %0b want 1", rsp_id); end
    n_checks++; if (rsp_data !== 32'hA) begin n_fail++; $display("FAIL bp_refill_data got %h want 0000000a", rsp_data); end
  endtask

  task automatic test_edge_shifts;
    logic [31:0] exp_pos, exp_neg;
`ifdef SHIFT_ARB_SRA_EN
    exp_pos = 32'h0000_0000;
    exp_neg = 32'hFFFF_FFFF;
`else
    exp_pos = 32'h8000_0000;
    exp_neg = 32'h8000_0000;
`endif
    drive(1'b0, 32'hFFFF_FFFF, 5'd31, 1'b0);
    n_checks++; if (rsp_data !== 32'h8000_0000) begin n_fail++; $display("FAIL edge_sll31 got %h want 80000000", rsp_data); end
    drive(1'b1, 32'h7FFF_FFFF, 5'd31, 1'b1);
    n_checks++; if (rsp_data !== exp_pos) begin n_fail++; $display("FAIL edge_sra31_pos got %h want %h", rsp_data, exp_pos); end
    drive(1'b1, 32'hFFFF_FFFF, 5'd31, 1'b1);
    n_checks++; if (rsp_data !== exp_neg) begin n_fail++; $display("FAIL edge_sra31_neg got %h want %h", rsp_data, exp_neg); end
    drive(1'b0, 32'h8000_0000, 5'd0, 1'b1);
    n_checks++; if (rsp_data !== 32'h8000_0000) begin n_fail++; $display("FAIL edge_sra0 got %h want 80000000", rsp_data); end
  endtask

  task automatic test_reset_mid;
    @(negedge clock);
    rsp_ready = 1'b0;
    drive(1'b0, 32'h7, 5'd0, 1'b0);
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_pending got %0b want 1", rsp_valid); end
    #2;
    reset = 1'b0;
    #1;
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_async_valid got %0b want 0", rsp_valid); end
    n_checks++; if (rsp_data !== 32'h0) begin n_fail++; $display("FAIL rmid_async_data got %h want 00000000", rsp_data); end
    @(negedge clock);
    reset     = 1'b1;
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_data = 32'h1; req0_shamt = 5'd3; req0_op = 1'b0;
    req1_valid = 1'b1; req1_data = 32'h1; req1_shamt = 5'd5; req1_op = 1'b0;
    #1;
    n_checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_first_grant got %0b%0b want 10", req0_ready, req1_ready); end
    @(posedge clock);
    @(negedge clock);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    n_checks++; if (rsp_id !== 1'b0) begin n_fail++; $display("FAIL rmid_rsp_id got %0b want 0", rsp_id); end
    n_checks++; if (rsp_data !== 32'h8) begin n_fail++; $display("FAIL rmid_rsp_data got %h want 00000008", rsp_data); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b0;
    rsp_ready  = 1'b1;
    req0_valid = 1'b0; req0_data = '0; req0_shamt = '0; req0_op = 1'b0;
    req1_valid = 1'b0; req1_data = '0; req1_shamt = '0; req1_op = 1'b0;
    test_reset;
    test_sll;
    test_sra;
    test_contention;
    test_back_pressure;
    test_edge_shifts;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Shares one 32-bit barrel-shift datapath (left-logical and right-arithmetic units) between two requesters: port 0 (ALU shift ops) and port 1 (multdiv unit). Each request is a valid/ready handshake. Grants use round-robin, and results come back through a single registered response channel with a requester ID. It sits between the execute stage and the shared shifter instances so that only one copy of the shift logic exists in the CPU.

## Interface
Parameters:
- `WIDTH`, 32: data width. Fixed by the shifter units; other values are unsupported.
- `SHW`, 5: shift-amount width.

Ports:
- `clock`, in, 1: sole clock, rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `req0_valid`, in, 1: port 0 request present.
- `req0_ready`, out, 1: port 0 request accepted this cycle when high together with `req0_valid`.
- `req0_data`, in, 32: port 0 operand.
- `req0_shamt`, in, 5: port 0 shift amount.
- `req0_op`, in, 1: port 0 operation. 0 = SLL, 1 = SRA.
- `req1_valid`, `req1_ready`, `req1_data`, `req1_shamt`, `req1_op`: same as the port 0 signals, for port 1.
- `rsp_valid`, out, 1: response register holds a result.
- `rsp_ready`, in, 1: consumer takes the result when high together with `rsp_valid`.
- `rsp_id`, out, 1: requester that owns the result.
- `rsp_data`, out, 32: shifted result.
- `busy`, out, 1: `rsp_valid` OR any `reqN_valid`.

## Operation
- Reset values:
  - `rsp_valid` = 0, `rsp_id` = 0, `rsp_data` = 0.
  - `last_grant` = 1, so port 0 wins the first contention.
  - `req0_ready` = 0 and `req1_ready` = 0 while `reset` is low.
- Output slot is free when `!rsp_valid || rsp_ready` (same-cycle drain and refill allowed).
- Grant selection:
  - Both ports valid: grant the port != `last_grant`.
  - Exactly one port valid: grant that port.
  - Neither valid: no grant.
- Ready generation: `reqN_ready` = (grant == N) AND slot free. This is combinational from both valids, `rsp_valid`, `rsp_ready`, and `last_grant`.
- On acceptance (`reqN_valid && reqN_ready`), at the clock edge:
  - Mux the port's operand, shamt and op into the shifter.
  - Register `rsp_data` = (op ? SRA : SLL)(data, shamt), `rsp_id` = N, `rsp_valid` = 1.
  - Set `last_grant` = N.
- `last_grant` changes only on an accepted request, never on a grant that is blocked by a full slot.
- Drain without refill: `rsp_valid && rsp_ready` with no acceptance sets `rsp_valid` to 0. `rsp_data` and `rsp_id` hold their old values.
- Stall: while `rsp_valid && !rsp_ready`, `rsp_data` and `rsp_id` hold stable and both readys are 0.
- Arithmetic rules:
  - SLL fills with zeros.
  - SRA fills with `data[31]`.
  - shamt 0 passes the operand through.
  - shamt 31 is legal.
  - The shift amount is never interpreted modulo anything beyond 5 bits.
- Requesters must hold data, shamt and op stable while valid is high and ready is low. The block does not check this.
- Reset asserted mid-operation: a pending result is discarded immediately (asynchronously), and fairness state returns to its reset value.

## Timing
- Latency: accepted at edge k, so `rsp_valid` = 1 with the result after edge k.
- Throughput: one result per cycle while `rsp_ready` stays high.
- Under continuous contention, ports alternate accepts: 0,1,0,1,...
- A port waits at most one accepted transaction from the other port (starvation bound = 1 grant).
- No combinational path from `reqN_*` to `rsp_*`.
- `reqN_ready` does depend combinationally on `rsp_ready`.
- Reset deassertion is synchronized externally; the block only requires async assertion.

## Configuration
- `SHIFT_ARB_SRA_EN` defined:
  - The SRA unit is instantiated.
  - `reqN_op` = 1 selects arithmetic right shift.
- `SHIFT_ARB_SRA_EN` undefined:
  - No SRA unit.
  - `reqN_op` is ignored, and every request performs SLL.
  - Handshake, arbitration and latency are unchanged.

## Test plan
- Single port 0 SLL: `data` = 0x00000001, shamt 4 → one cycle later `rsp_valid` = 1, `rsp_id` = 0, `rsp_data` = 0x00000010. Also shamt 0 on 0xDEADBEEF → 0xDEADBEEF.
- SRA, with the macro defined: port 1, `data` = 0x80000000, shamt 4, op 1 → `rsp_data` = 0xF8000000, `rsp_id` = 1. Without the macro, the same stimulus → 0x00000000.
- Contention: both ports valid for 4 cycles with `rsp_ready` tied high → accepts on successive cycles with `rsp_id` sequence 0,1,0,1 (first grant to 0 after reset).
- Backpressure: hold `rsp_ready` = 0 for 3 cycles after a result → `rsp_data`/`rsp_id` stable, both readys 0. Raise `rsp_ready` → same-cycle refill, and the next result appears on the following cycle.
- Edge shifts: SLL 0xFFFFFFFF shamt 31 → 0x80000000. SRA 0x7FFFFFFF shamt 31 → 0x00000000.
- Reset mid-operation: `rsp_valid` = 1 while stalled, then `reset` pulled low between edges → `rsp_valid` drops to 0 immediately. After release, contention grants port 0 first.
